// File: rtl/bsg_counter_dynamic_limit_multi.sv
// Bank of independent counters with per-channel dynamic period.
// Each channel wraps or saturates (one-shot) at its own limit.
module bsg_counter_dynamic_limit_multi #(
    parameter int width_p = 16,
    parameter int els_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         en_i,
    input  logic [els_p-1:0]         clear_i,
    input  logic [els_p-1:0]         mode_i,
    input  logic [els_p*width_p-1:0] limit_i,
    output logic [els_p*width_p-1:0] counter_o,
    output logic [els_p-1:0]         term_o,
    output logic [els_p-1:0]         wrap_o,
    output logic [els_p-1:0]         done_o
);

    localparam logic [width_p-1:0] one_lp = width_p'(1);

    logic [els_p-1:0][width_p-1:0] cnt_q, cnt_d;
    logic [els_p-1:0][width_p-1:0] lim;
    logic [els_p-1:0][width_p-1:0] last;
    logic [els_p-1:0]              done_q, done_d;
    logic [els_p-1:0]              wrap_q, wrap_d;
    logic [els_p-1:0]              term;

    assign lim = limit_i;

    // last legal count; L==0 naturally becomes all-ones
    always_comb begin
        last = '0;
        term = '0;
        for (int i = 0; i < els_p; i++) begin
            last[i] = lim[i] - one_lp;
            if (lim[i] == '0) begin
                term[i] = &cnt_q[i];
            end else begin
                term[i] = {1'b0, cnt_q[i]} >= {1'b0, last[i]};
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        wrap_d = '0;
        for (int i = 0; i < els_p; i++) begin
            if (clear_i[i]) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (en_i[i] && done_q[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (en_i[i] && term[i]) begin
                wrap_d[i] = 1'b1;
                if (mode_i[i]) begin
                    cnt_d[i]  = last[i];
                    done_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = '0;
                end
            end else if (en_i[i]) begin
                cnt_d[i] = cnt_q[i] + one_lp;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            done_q <= '0;
            wrap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign counter_o = cnt_q;
    assign term_o    = term;
    assign wrap_o    = wrap_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_multi.sv
// Directed bench for bsg_counter_dynamic_limit_multi, width 4, two channels.
// Inputs change on the falling edge; outputs are checked 2 ns later.
module tb_bsg_counter_dynamic_limit_multi;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [1:0] en_i, clear_i, mode_i;
    logic [7:0] limit_i;
    logic [7:0] counter_o;
    logic [1:0] term_o, wrap_o, done_o;

    int checks = 0;
    int failures = 0;

    bsg_counter_dynamic_limit_multi #(.width_p(4), .els_p(2)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .clear_i  (clear_i),
        .mode_i   (mode_i),
        .limit_i  (limit_i),
        .counter_o(counter_o),
        .term_o   (term_o),
        .wrap_o   (wrap_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] en;
        logic [1:0] clr;
        logic [1:0] mode;
        logic [7:0] lim;
        logic [7:0] cnt;
        logic [1:0] term;
        logic [1:0] wrap;
        logic [1:0] done;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [1:0] clr,
                         input logic [1:0] mode, input logic [7:0] lim);
        en_i    = en;
        clear_i = clr;
        mode_i  = mode;
        limit_i = lim;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 8'h00);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 8'h00);
        @(negedge clk_i);
        #2;
        chk("rst_cnt", 32'(counter_o), 32'h0);
        chk("rst_wrap", 32'(wrap_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_term", 32'(term_o), 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // ch0 wrap L=3, ch1 one-shot L=5, then clear ch1
        tv[0] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h00, 2'b00, 2'b00, 2'b00};
        tv[1] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h11, 2'b00, 2'b00, 2'b00};
        tv[2] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h22, 2'b01, 2'b00, 2'b00};
        tv[3] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h30, 2'b00, 2'b01, 2'b00};
        tv[4] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h41, 2'b10, 2'b00, 2'b00};
        tv[5] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h42, 2'b11, 2'b10, 2'b10};
        tv[6] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h40, 2'b10, 2'b01, 2'b10};
        tv[7] = '{2'b11, 2'b00, 2'b10, 8'h53, 8'h41, 2'b10, 2'b00, 2'b10};
        tv[8] = '{2'b00, 2'b10, 2'b10, 8'h53, 8'h42, 2'b11, 2'b00, 2'b10};
        tv[9] = '{2'b00, 2'b00, 2'b10, 8'h53, 8'h02, 2'b01, 2'b00, 2'b00};

        for (int k = 0; k < 10; k++) begin
            drive(tv[k].en, tv[k].clr, tv[k].mode, tv[k].lim);
            #2;
            chk($sformatf("tv%0d_cnt", k), 32'(counter_o), 32'(tv[k].cnt));
            chk($sformatf("tv%0d_term", k), 32'(term_o), 32'(tv[k].term));
            chk($sformatf("tv%0d_wrap", k), 32'(wrap_o), 32'(tv[k].wrap));
            chk($sformatf("tv%0d_done", k), 32'(done_o), 32'(tv[k].done));
            @(negedge clk_i);
        end

        // L=0 on ch0: full 16-count period
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(2'b01, 2'b00, 2'b00, 8'h00);
            #2;
            chk($sformatf("l0_cnt%0d", k), 32'(counter_o[3:0]), k % 16);
            chk($sformatf("l0_term%0d", k), 32'(term_o[0]), 32'(k == 15));
            chk($sformatf("l0_wrap%0d", k), 32'(wrap_o[0]), 32'(k == 16));
            @(negedge clk_i);
        end
        chk("l0_ch1_idle", 32'(counter_o[7:4]), 32'h0);

        // limit lowered below the current count
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(2'b01, 2'b00, 2'b00, 8'h00);
            @(negedge clk_i);
        end
        drive(2'b01, 2'b00, 2'b00, 8'h04);
        #2;
        chk("low_cnt9", 32'(counter_o[3:0]), 32'h9);
        chk("low_term", 32'(term_o[0]), 32'h1);
        @(negedge clk_i);
        #2;
        chk("low_reload", 32'(counter_o[3:0]), 32'h0);
        chk("low_wrap", 32'(wrap_o[0]), 32'h1);
        chk("low_term0", 32'(term_o[0]), 32'h0);
        @(negedge clk_i);

        // clear beats a terminal count; hold with en low
        do_reset();
        drive(2'b01, 2'b00, 2'b00, 8'h02);
        #2;
        chk("clr_c0", 32'(counter_o[3:0]), 32'h0);
        @(negedge clk_i);
        drive(2'b01, 2'b01, 2'b00, 8'h02);
        #2;
        chk("clr_c1", 32'(counter_o[3:0]), 32'h1);
        chk("clr_term", 32'(term_o[0]), 32'h1);
        @(negedge clk_i);
        drive(2'b01, 2'b00, 2'b00, 8'h02);
        #2;
        chk("clr_cnt", 32'(counter_o[3:0]), 32'h0);
        chk("clr_nowrap", 32'(wrap_o[0]), 32'h0);
        @(negedge clk_i);
        for (int k = 0; k < 3; k++) begin
            drive(2'b00, 2'b00, 2'b00, 8'h02);
            #2;
            chk($sformatf("hold_cnt%0d", k), 32'(counter_o[3:0]), 32'h1);
            chk($sformatf("hold_wrap%0d", k), 32'(wrap_o[0]), 32'h0);
            @(negedge clk_i);
        end

        // async reset mid-count with ch1 done
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 2'b00, 2'b10, 8'h20);
            @(negedge clk_i);
        end
        #2;
        chk("ar_cnt6", 32'(counter_o[3:0]), 32'h6);
        chk("ar_done", 32'(done_o), 32'h2);
        reset_i = 1'b1;
        #1;
        chk("ar_cnt", 32'(counter_o), 32'h0);
        chk("ar_wrap", 32'(wrap_o), 32'h0);
        chk("ar_done0", 32'(done_o), 32'h0);
        chk("ar_term", 32'(term_o), 32'h0);
        limit_i = 8'h10;
        #1;
        chk("ar_term_l1", 32'(term_o), 32'h2);
        @(negedge clk_i);
        chk("ar_held", 32'(counter_o), 32'h0);
        reset_i = 1'b0;

        // identical stimulus on both channels; mode flip keeps done
        for (int k = 0; k < 8; k++) begin
            logic [3:0] e;
            e = (k < 2) ? 4'(k) : 4'd2;
            drive(2'b11, 2'b00, (k >= 6) ? 2'b00 : 2'b11, 8'h33);
            #2;
            chk($sformatf("id_cnt%0d", k), 32'(counter_o), 32'({e, e}));
            chk($sformatf("id_done%0d", k), 32'(done_o),
                (k >= 3) ? 32'h3 : 32'h0);
            chk($sformatf("id_wrap%0d", k), 32'(wrap_o),
                (k == 3) ? 32'h3 : 32'h0);
            @(negedge clk_i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
